// File: rtl/nor_block_lock_ctrl.sv
// nor_block_lock_ctrl
//
// Issues one block lock-bit change to a parallel NOR flash and verifies it.
// Command sequence on the flash bus, all writes at the block base address:
//   0x0060 (Lock Setup), 0x0001 (Lock Confirm) or 0x00D0 (Unlock Confirm),
//   0x0090 (Read Identifier), then one read of the lock-config word at
//   BASE|2, a bus turnaround cycle, and 0x00FF (Read Array) to leave the part
//   in array-read mode.
//
// Ports
//   CLK       in    1   system clock, all logic on posedge
//   RST       in    1   synchronous reset, active high
//   START     in    1   operation request, sampled only in IDLE
//   BLK_ADDR  in    24  any word address inside the target block
//   LOCK      in    1   1 = lock block, 0 = unlock block
//   BUSY      out   1   controller owns the flash bus
//   DONE      out   1   one-cycle end-of-operation pulse
//   ERR       out   1   read-back lock bit disagrees with request (valid with DONE)
//   STAT      out   8   read-back lock-config word bits [7:0]
//   ADDR      out   24  flash word address
//   DATA      inout 16  flash data, driven only while writing a command
//   CE        out   1   flash chip enable, active low
//   WE        out   1   flash write enable, active low
//   OE        out   1   flash output enable, active low
//   DBG_STATE out   3   current FSM state (0 IDLE, 1 WR, 2 RD, 3 TURN, 4 FIN)
//
// Request handshake: START is a level that is only looked at while the
// controller is IDLE; the edge that sees START=1 in IDLE accepts the request
// and latches BLK_ADDR/LOCK. BUSY rises in the following cycle and stays high
// through the single DONE cycle. START seen while BUSY is dropped, never
// queued; a request held across DONE is accepted after one IDLE cycle.

module nor_block_lock_ctrl #(
  parameter int T_WP     = 3,
  parameter int T_WPH    = 3,
  parameter int T_ACC    = 11,
  parameter int BLK_BITS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [23:0] BLK_ADDR,
  input  logic        LOCK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  STAT,
  output logic [23:0] ADDR,
  inout  wire  [15:0] DATA,
  output logic        CE,
  output logic        WE,
  output logic        OE,
  output logic [2:0]  DBG_STATE
);

  localparam int WR_LEN  = T_WP + T_WPH;
  localparam int MAX_CNT = (WR_LEN > T_ACC) ? WR_LEN : T_ACC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [23:0] BASE_MASK = ~((24'd1 << BLK_BITS) - 24'd1);
  localparam logic [23:0] ID_OFFSET = 24'h000002;

  localparam logic [15:0] CMD_LOCK_SETUP = 16'h0060;
  localparam logic [15:0] CMD_LOCK_CONF  = 16'h0001;
  localparam logic [15:0] CMD_UNLOCK     = 16'h00D0;
  localparam logic [15:0] CMD_READ_ID    = 16'h0090;
  localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_TURN = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  // Index of the command being written: 0 setup, 1 confirm, 2 read-ID,
  // 3 read-array. The read phase sits between index 2 and index 3.
  logic [1:0]       cmd_idx, cmd_d;
  logic [23:0]      base_q;
  logic             lock_q;
  logic [7:0]       stat_q;
  logic             err_q;

  logic             accept;
  logic             rd_last;
  logic             data_oe;
  logic [15:0]      data_out;
  logic [15:0]      cmd_word;

  assign accept  = (state == S_IDLE) && START;
  assign rd_last = (state == S_RD) && (cnt == CNT_W'(T_ACC - 1));

  always_comb begin
    cmd_word = CMD_LOCK_SETUP;
    case (cmd_idx)
      2'd0: cmd_word = CMD_LOCK_SETUP;
      2'd1: cmd_word = lock_q ? CMD_LOCK_CONF : CMD_UNLOCK;
      2'd2: cmd_word = CMD_READ_ID;
      2'd3: cmd_word = CMD_READ_ARRAY;
      default: cmd_word = CMD_LOCK_SETUP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cmd_idx <= 2'd0;
      base_q  <= '0;
      lock_q  <= 1'b0;
      stat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cmd_idx <= cmd_d;
      if (accept) begin
        base_q <= BLK_ADDR & BASE_MASK;
        lock_q <= LOCK;
        err_q  <= 1'b0;
      end
      if (rd_last) begin
        stat_q <= DATA[7:0];
        err_q  <= (DATA[0] != lock_q);
      end
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + CNT_W'(1);
    cmd_d    = cmd_idx;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    ADDR     = '0;
    CE       = 1'b1;
    WE       = 1'b1;
    OE       = 1'b1;
    data_oe  = 1'b0;
    data_out = '0;

    case (state)
      S_IDLE: begin
        BUSY  = 1'b0;
        cnt_d = '0;
        cmd_d = 2'd0;
        if (START) state_d = S_WR;
      end

      S_WR: begin
        // Strobes low for T_WP cycles, then high for T_WPH cycles while
        // address and data are still held for the flash's hold time.
        ADDR     = base_q;
        data_oe  = 1'b1;
        data_out = cmd_word;
        if (cnt < CNT_W'(T_WP)) begin
          CE = 1'b0;
          WE = 1'b0;
        end
        if (cnt == CNT_W'(WR_LEN - 1)) begin
          cnt_d = '0;
          cmd_d = cmd_idx + 2'd1;
          if (cmd_idx == 2'd2)      state_d = S_RD;
          else if (cmd_idx == 2'd3) state_d = S_FIN;
        end
      end

      S_RD: begin
        ADDR = base_q | ID_OFFSET;
        CE   = 1'b0;
        OE   = 1'b0;
        if (rd_last) begin
          cnt_d   = '0;
          state_d = S_TURN;
        end
      end

      S_TURN: begin
        // One idle bus cycle so the flash releases DATA before we drive it.
        ADDR    = base_q;
        cnt_d   = '0;
        state_d = S_WR;
      end

      S_FIN: begin
        ADDR    = base_q;
        DONE    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        BUSY    = 1'b0;
        cnt_d   = '0;
        cmd_d   = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign DATA      = data_oe ? data_out : 16'hzzzz;
  assign ERR       = err_q;
  assign STAT      = stat_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_nor_block_lock_ctrl.sv
// tb_nor_block_lock_ctrl
//
// Directed bench for nor_block_lock_ctrl. A small flash model returns
// flash_id while CE=OE=0; whenever the controller is not in a write phase
// the bench holds a fixed pattern on DATA so any stray drive by the DUT
// corrupts the observed value. A bus monitor logs command writes and reads
// and checks strobe timing every cycle.

module tb_nor_block_lock_ctrl;

  localparam int T_WP  = 3;
  localparam int T_WPH = 3;
  localparam int T_ACC = 11;
  localparam int N_LAT = 4 * (T_WP + T_WPH) + T_ACC + 1;

  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_WR   = 3'd1;
  localparam logic [2:0]  S_RD   = 3'd2;
  localparam logic [15:0] KEEP   = 16'h5A5A;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [23:0] BLK_ADDR = '0;
  logic        LOCK = 1'b0;
  logic        BUSY, DONE, ERR, CE, WE, OE;
  logic [7:0]  STAT;
  logic [23:0] ADDR;
  logic [2:0]  DBG_STATE;
  wire  [15:0] DATA;

  logic [15:0] flash_id = 16'h0000;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [23:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [23:0] rd_addr_q[$];

  int   we_run = 0;
  int   ce_run = 0;
  int   oe_run = 0;
  logic ce_rd  = 1'b0;
  logic prev_we = 1'b1;
  logic prev_oe = 1'b1;

  nor_block_lock_ctrl #(
    .T_WP(T_WP), .T_WPH(T_WPH), .T_ACC(T_ACC), .BLK_BITS(16)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .BLK_ADDR(BLK_ADDR), .LOCK(LOCK),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STAT(STAT), .ADDR(ADDR),
    .DATA(DATA), .CE(CE), .WE(WE), .OE(OE), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // flash model plus keeper pattern outside write phases
  assign DATA = (DBG_STATE != S_WR) ?
                ((CE === 1'b0 && OE === 1'b0) ? flash_id : KEEP) : 16'hzzzz;

  // bus monitor
  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (RST !== 1'b0) begin
      we_run = 0; ce_run = 0; oe_run = 0; ce_rd = 1'b0;
      prev_we = 1'b1; prev_oe = 1'b1;
    end else begin
      total++;
      if (OE === 1'b0 && WE === 1'b0) begin
        bad++; $display("FAIL bus_oe_we_both_low got OE=%b WE=%b", OE, WE);
      end
      if (DBG_STATE !== S_WR) begin
        total++;
        if (DATA !== ((OE === 1'b0) ? flash_id : KEEP)) begin
          bad++;
          $display("FAIL bus_data_undriven state=%0d got=%h exp=%h", DBG_STATE, DATA,
                   (OE === 1'b0) ? flash_id : KEEP);
        end
      end
      if (WE === 1'b0 && prev_we === 1'b1) begin
        wr_addr_q.push_back(ADDR);
        wr_data_q.push_back(DATA);
      end
      if (OE === 1'b0 && prev_oe === 1'b1) rd_addr_q.push_back(ADDR);

      if (WE === 1'b0) we_run++;
      else if (we_run != 0) begin
        total++;
        if (we_run != T_WP) begin bad++; $display("FAIL we_low_run got=%0d exp=%0d", we_run, T_WP); end
        we_run = 0;
      end
      if (OE === 1'b0) oe_run++;
      else if (oe_run != 0) begin
        total++;
        if (oe_run != T_ACC) begin bad++; $display("FAIL oe_low_run got=%0d exp=%0d", oe_run, T_ACC); end
        oe_run = 0;
      end
      if (CE === 1'b0) begin
        ce_run++;
        if (OE === 1'b0) ce_rd = 1'b1;
      end else if (ce_run != 0) begin
        total++;
        if (ce_run != (ce_rd ? T_ACC : T_WP)) begin
          bad++; $display("FAIL ce_low_run got=%0d exp=%0d", ce_run, ce_rd ? T_ACC : T_WP);
        end
        ce_run = 0; ce_rd = 1'b0;
      end
      prev_we = WE;
      prev_oe = OE;
    end
  end

  // driver tasks
  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
  endtask

  // Returns at the negedge just after the accepting edge (k = 0).
  task automatic issue(input logic [23:0] a, input logic l);
    @(negedge CLK); START = 1'b1; BLK_ADDR = a; LOCK = l;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (DONE !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
  endtask

  // tests
  task automatic test_reset();
    repeat (3) @(negedge CLK);
    total++; if (CE !== 1'b1 || WE !== 1'b1 || OE !== 1'b1) begin
      bad++; $display("FAIL reset_strobes got CE=%b WE=%b OE=%b exp 111", CE, WE, OE); end
    total++; if (DATA !== KEEP) begin bad++; $display("FAIL reset_data_z got=%h exp=%h", DATA, KEEP); end
    total++; if (ADDR !== 24'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", ADDR); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      bad++; $display("FAIL reset_flags got BUSY=%b DONE=%b ERR=%b exp 000", BUSY, DONE, ERR); end
    total++; if (STAT !== 8'h00) begin bad++; $display("FAIL reset_stat got=%h exp=00", STAT); end
    total++; if (DBG_STATE !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", DBG_STATE); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (BUSY !== 1'b0 || DBG_STATE !== S_IDLE) begin
      bad++; $display("FAIL idle_after_reset got BUSY=%b state=%0d", BUSY, DBG_STATE); end
  endtask

  task automatic test_unlock();
    int k;
    logic [15:0] ed[4];
    ed = '{16'h0060, 16'h00D0, 16'h0090, 16'h00FF};
    flash_id = 16'h0000;
    clear_logs();
    issue(24'h02ABCD, 1'b0);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL unlock_busy_rise got=%b exp=1", BUSY); end
    wait_done(k);
    total++; if (k != N_LAT) begin bad++; $display("FAIL unlock_latency got=%0d exp=%0d", k, N_LAT); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL unlock_busy_at_done got=%b exp=1", BUSY); end
    total++; if (STAT !== 8'h00 || ERR !== 1'b0) begin
      bad++; $display("FAIL unlock_result got STAT=%h ERR=%b exp 00/0", STAT, ERR); end
    total++; if (wr_data_q.size() != 4) begin
      bad++; $display("FAIL unlock_write_count got=%0d exp=4", wr_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_data_q.size()) begin
        total++; if (wr_data_q[i] !== ed[i] || wr_addr_q[i] !== 24'h020000) begin
          bad++; $display("FAIL unlock_write%0d got=%h@%h exp=%h@020000", i, wr_data_q[i], wr_addr_q[i], ed[i]); end
      end
    end
    total++; if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 24'h020002) begin
      bad++; $display("FAIL unlock_read_addr got n=%0d a=%h exp 1@020002", rd_addr_q.size(), rd_addr_q[0]); end
    @(negedge CLK);
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL unlock_after_done got BUSY=%b DONE=%b exp 00", BUSY, DONE); end
  endtask

  task automatic test_lock();
    int k;
    logic [15:0] ed[4];
    ed = '{16'h0060, 16'h0001, 16'h0090, 16'h00FF};
    flash_id = 16'h0001;
    clear_logs();
    issue(24'h050000, 1'b1);
    wait_done(k);
    total++; if (k != N_LAT) begin bad++; $display("FAIL lock_latency got=%0d exp=%0d", k, N_LAT); end
    total++; if (STAT !== 8'h01 || ERR !== 1'b0) begin
      bad++; $display("FAIL lock_result got STAT=%h ERR=%b exp 01/0", STAT, ERR); end
    total++; if (wr_data_q.size() != 4) begin
      bad++; $display("FAIL lock_write_count got=%0d exp=4", wr_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_data_q.size()) begin
        total++; if (wr_data_q[i] !== ed[i] || wr_addr_q[i] !== 24'h050000) begin
          bad++; $display("FAIL lock_write%0d got=%h@%h exp=%h@050000", i, wr_data_q[i], wr_addr_q[i], ed[i]); end
      end
    end
    total++; if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 24'h050002) begin
      bad++; $display("FAIL lock_read_addr got n=%0d a=%h exp 1@050002", rd_addr_q.size(), rd_addr_q[0]); end
    @(negedge CLK);
  endtask

  task automatic test_stuck_locked();
    int k;
    flash_id = 16'h0001;
    clear_logs();
    issue(24'h7F1234, 1'b0);
    wait_done(k);
    total++; if (k != N_LAT) begin bad++; $display("FAIL stuck_latency got=%0d exp=%0d", k, N_LAT); end
    total++; if (ERR !== 1'b1 || STAT !== 8'h01) begin
      bad++; $display("FAIL stuck_err got ERR=%b STAT=%h exp 1/01", ERR, STAT); end
    total++; if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 24'h7F0002) begin
      bad++; $display("FAIL stuck_read_addr got n=%0d a=%h exp 1@7F0002", rd_addr_q.size(), rd_addr_q[0]); end
    repeat (3) @(negedge CLK);
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL stuck_err_hold got=%b exp=1", ERR); end
    flash_id = 16'h0000;
    issue(24'h7F1234, 1'b0);
    total++; if (ERR !== 1'b0 || STAT !== 8'h01) begin
      bad++; $display("FAIL stuck_err_clear got ERR=%b STAT=%h exp 0/01", ERR, STAT); end
    wait_done(k);
    total++; if (k != N_LAT || ERR !== 1'b0 || STAT !== 8'h00) begin
      bad++; $display("FAIL stuck_retry got k=%0d ERR=%b STAT=%h exp %0d/0/00", k, ERR, STAT, N_LAT); end
    @(negedge CLK);
  endtask

  task automatic test_busy_ignore();
    int k;
    int dc0;
    logic [15:0] ed[4];
    ed = '{16'h0060, 16'h0001, 16'h0090, 16'h00FF};
    flash_id = 16'h0001;
    clear_logs();
    dc0 = done_cnt;
    issue(24'h130000, 1'b1);
    k = 0;
    while (DONE !== 1'b1 && k < 100) begin
      START = (k == 5 || k == 20 || k == 35);
      if (k == 3) begin LOCK = 1'b0; BLK_ADDR = 24'hFFFFFF; end
      @(negedge CLK); k++;
    end
    START = 1'b0;
    total++; if (k != N_LAT) begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", k, N_LAT); end
    total++; if (STAT !== 8'h01 || ERR !== 1'b0) begin
      bad++; $display("FAIL busy_result got STAT=%h ERR=%b exp 01/0", STAT, ERR); end
    total++; if (wr_data_q.size() != 4) begin
      bad++; $display("FAIL busy_write_count got=%0d exp=4", wr_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_data_q.size()) begin
        total++; if (wr_data_q[i] !== ed[i] || wr_addr_q[i] !== 24'h130000) begin
          bad++; $display("FAIL busy_write%0d got=%h@%h exp=%h@130000", i, wr_data_q[i], wr_addr_q[i], ed[i]); end
      end
    end
    repeat (10) @(negedge CLK);
    total++; if (done_cnt - dc0 != 1 || DBG_STATE !== S_IDLE) begin
      bad++; $display("FAIL busy_single_done got dones=%0d state=%0d exp 1/0", done_cnt - dc0, DBG_STATE); end
  endtask

  task automatic test_back_to_back();
    int k;
    int k2;
    flash_id = 16'h0000;
    clear_logs();
    @(negedge CLK); START = 1'b1; BLK_ADDR = 24'h210010; LOCK = 1'b0;
    @(negedge CLK);
    wait_done(k);
    total++; if (k != N_LAT || STAT !== 8'h00 || ERR !== 1'b0) begin
      bad++; $display("FAIL b2b_first got k=%0d STAT=%h ERR=%b exp %0d/00/0", k, STAT, ERR, N_LAT); end
    @(negedge CLK);
    total++; if (BUSY !== 1'b0 || DBG_STATE !== S_IDLE) begin
      bad++; $display("FAIL b2b_idle_gap got BUSY=%b state=%0d exp 0/0", BUSY, DBG_STATE); end
    BLK_ADDR = 24'h330000; LOCK = 1'b1; flash_id = 16'h0001;
    @(negedge CLK);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got BUSY=%b exp=1", BUSY); end
    START = 1'b0;
    wait_done(k2);
    total++; if (k2 != N_LAT || STAT !== 8'h01 || ERR !== 1'b0) begin
      bad++; $display("FAIL b2b_second got k=%0d STAT=%h ERR=%b exp %0d/01/0", k2, STAT, ERR, N_LAT); end
    total++; if (wr_data_q.size() != 8 || wr_data_q[5] !== 16'h0001 || wr_addr_q[4] !== 24'h330000) begin
      bad++; $display("FAIL b2b_second_writes got n=%0d d5=%h a4=%h exp 8/0001/330000",
                      wr_data_q.size(), wr_data_q[5], wr_addr_q[4]); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_op();
    int k;
    int dc0;
    flash_id = 16'h0000;
    clear_logs();
    dc0 = done_cnt;
    issue(24'h0A0000, 1'b0);
    k = 0;
    while (k < 22) begin @(negedge CLK); k++; end
    total++; if (DBG_STATE !== S_RD) begin bad++; $display("FAIL rstmid_in_read got=%0d exp=%0d", DBG_STATE, S_RD); end
    RST = 1'b1;
    @(negedge CLK);
    total++; if (CE !== 1'b1 || WE !== 1'b1 || OE !== 1'b1) begin
      bad++; $display("FAIL rstmid_strobes got CE=%b WE=%b OE=%b exp 111", CE, WE, OE); end
    total++; if (DATA !== KEEP || BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL rstmid_bus got DATA=%h BUSY=%b DONE=%b exp %h/0/0", DATA, BUSY, DONE, KEEP); end
    #2 RST = 1'b0;
    repeat (50) @(negedge CLK);
    total++; if (done_cnt != dc0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - dc0); end
    clear_logs();
    issue(24'h0A0000, 1'b0);
    wait_done(k);
    total++; if (k != N_LAT || ERR !== 1'b0 || STAT !== 8'h00) begin
      bad++; $display("FAIL rstmid_fresh got k=%0d ERR=%b STAT=%h exp %0d/0/00", k, ERR, STAT, N_LAT); end
    total++; if (wr_data_q.size() != 4 || wr_data_q[0] !== 16'h0060 || wr_data_q[1] !== 16'h00D0) begin
      bad++; $display("FAIL rstmid_fresh_writes got n=%0d d0=%h d1=%h exp 4/0060/00D0",
                      wr_data_q.size(), wr_data_q[0], wr_data_q[1]); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lock();
    test_stuck_locked();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
